// File: rtl/instr_fetch_seq.sv
// Instruction fetch and phase sequencer: fetches 16-bit words over req/ack,
// splits them into decoder fields and drives the cnt_clk execute phases.
module instr_fetch_seq #(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 16,
    parameter int LAST_PHASE = 3,
    parameter int CNT_W      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               PC_Ctr,
    output logic [1:0]         SM,
    output logic [3:0]         OP,
    output logic [1:0]         RD,
    output logic [7:0]         IMM,
    output logic [CNT_W-1:0]   cnt_clk,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valid
);

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_WAIT = 2'b01,
        EXEC       = 2'b10
    } state_t;

    state_t              state_r, state_nx_s;
    logic [ADDR_W-1:0]   pc_r, pc_nx_s;
    logic [INSTR_W-1:0]  ir_r, ir_nx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
    logic                req_r, req_nx_s;
    logic                valid_r, valid_nx_s;

    // State and datapath registers; reset aborts any fetch or execute at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH_IDLE;
            pc_r    <= {ADDR_W{1'b0}};
            ir_r    <= {INSTR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
            ir_r    <= ir_nx_s;
            cnt_r   <= cnt_nx_s;
            req_r   <= req_nx_s;
            valid_r <= valid_nx_s;
        end
    end

    // Next-state and next-register values for the fetch/execute sequence.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        ir_nx_s    = ir_r;
        cnt_nx_s   = cnt_r;
        req_nx_s   = req_r;
        valid_nx_s = valid_r;
        case (state_r)
            FETCH_IDLE: begin
                if (run) begin
                    state_nx_s = FETCH_WAIT;
                    req_nx_s   = 1'b1;
                end else begin
                    req_nx_s   = 1'b0;
                end
            end
            FETCH_WAIT: begin
                if (req_r && imem_ack) begin
                    ir_nx_s    = imem_rdata;
                    req_nx_s   = 1'b0;
                    cnt_nx_s   = CNT_W'(1);
                    valid_nx_s = 1'b1;
                    state_nx_s = EXEC;
                end else begin
                    req_nx_s   = 1'b1;
                end
            end
            EXEC: begin
                if (cnt_r == CNT_W'(LAST_PHASE)) begin
                    // Only an explicit 0 jumps; X/Z from an undriven decoder falls to increment.
                    if (PC_Ctr == 1'b0) begin
                        pc_nx_s = ADDR_W'(ir_r[7:0]);
                    end else begin
                        pc_nx_s = pc_r + ADDR_W'(1);
                    end
                    cnt_nx_s   = {CNT_W{1'b0}};
                    valid_nx_s = 1'b0;
                    if (run) begin
                        state_nx_s = FETCH_WAIT;
                        req_nx_s   = 1'b1;
                    end else begin
                        state_nx_s = FETCH_IDLE;
                        req_nx_s   = 1'b0;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nx_s = FETCH_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
                req_nx_s   = 1'b0;
                valid_nx_s = 1'b0;
            end
        endcase
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign cnt_clk     = cnt_r;
    assign instr_valid = valid_r;
    assign SM          = ir_r[15:14];
    assign OP          = ir_r[13:10];
    assign RD          = ir_r[9:8];
    assign IMM         = ir_r[7:0];

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed table-driven bench for instr_fetch_seq plus async-reset sequences.
module tb_instr_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        PC_Ctr;
    logic [1:0]  SM;
    logic [3:0]  OP;
    logic [1:0]  RD;
    logic [7:0]  IMM;
    logic [1:0]  cnt_clk;
    logic [7:0]  pc;
    logic        instr_valid;

    int n_cmp;
    int n_bad;

    instr_fetch_seq dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_Ctr(PC_Ctr),
        .SM(SM), .OP(OP), .RD(RD), .IMM(IMM),
        .cnt_clk(cnt_clk), .pc(pc), .instr_valid(instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        ack;
        logic [15:0] rdata;
        logic        pc_ctr;
        logic        req;
        logic [7:0]  addr;
        logic [1:0]  cnt;
        logic        valid;
        logic [15:0] ir;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [0:NV-1];

    function automatic vec_t mk(logic r, logic a, logic [15:0] d, logic c,
                                logic q, logic [7:0] ad, logic [1:0] n,
                                logic v, logic [15:0] i);
        vec_t t;
        t.run = r; t.ack = a; t.rdata = d; t.pc_ctr = c;
        t.req = q; t.addr = ad; t.cnt = n; t.valid = v; t.ir = i;
        return t;
    endfunction

    function automatic logic [35:0] observed();
        return {imem_req, imem_addr, pc, cnt_clk, instr_valid, SM, OP, RD, IMM};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic [15:0] d, input logic c);
        @(negedge clk);
        run = r; imem_ack = a; imem_rdata = d; PC_Ctr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000; PC_Ctr = 1'b1;

        //                run   ack   rdata     pcc   req   addr   cnt    vld   ir
        vecs[0]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 16'h0000);
        vecs[1]  = mk(1'b1, 1'b1, 16'h4123, 1'b1, 1'b0, 8'h00, 2'd1, 1'b1, 16'h4123);
        vecs[2]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 2'd2, 1'b1, 16'h4123);
        vecs[3]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 2'd3, 1'b1, 16'h4123);
        vecs[4]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h01, 2'd0, 1'b0, 16'h4123);
        vecs[5]  = mk(1'b1, 1'b1, 16'hC050, 1'b1, 1'b0, 8'h01, 2'd1, 1'b1, 16'hC050);
        vecs[6]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h01, 2'd2, 1'b1, 16'hC050);
        vecs[7]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h01, 2'd3, 1'b1, 16'hC050);
        vecs[8]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h50, 2'd0, 1'b0, 16'hC050);
        vecs[9]  = mk(1'b1, 1'b1, 16'hC0FF, 1'b1, 1'b0, 8'h50, 2'd1, 1'b1, 16'hC0FF);
        vecs[10] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h50, 2'd2, 1'b1, 16'hC0FF);
        vecs[11] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h50, 2'd3, 1'b1, 16'hC0FF);
        vecs[12] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hFF, 2'd0, 1'b0, 16'hC0FF);
        vecs[13] = mk(1'b1, 1'b1, 16'h4123, 1'b1, 1'b0, 8'hFF, 2'd1, 1'b1, 16'h4123);
        vecs[14] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hFF, 2'd2, 1'b1, 16'h4123);
        vecs[15] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hFF, 2'd3, 1'b1, 16'h4123);
        vecs[16] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 16'h4123);
        vecs[17] = mk(1'b1, 1'b0, 16'hABCD, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 16'h4123);
        vecs[18] = mk(1'b1, 1'b0, 16'hABCD, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 16'h4123);
        vecs[19] = mk(1'b1, 1'b0, 16'hABCD, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 16'h4123);
        vecs[20] = mk(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 8'h00, 2'd1, 1'b1, 16'h1234);
        vecs[21] = mk(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 8'h00, 2'd2, 1'b1, 16'h1234);
        vecs[22] = mk(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 8'h00, 2'd3, 1'b1, 16'h1234);
        vecs[23] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h01, 2'd0, 1'b0, 16'h1234);
        vecs[24] = mk(1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 8'h01, 2'd0, 1'b0, 16'h1234);
        vecs[25] = mk(1'b0, 1'b0, 16'h5555, 1'b1, 1'b0, 8'h01, 2'd0, 1'b0, 16'h1234);
        vecs[26] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h01, 2'd0, 1'b0, 16'h1234);
        vecs[27] = mk(1'b1, 1'b1, 16'h4123, 1'b1, 1'b0, 8'h01, 2'd1, 1'b1, 16'h4123);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset", observed(), 36'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].run, vecs[i].ack, vecs[i].rdata, vecs[i].pc_ctr);
            check($sformatf("vec[%0d]", i), observed(),
                  {vecs[i].req, vecs[i].addr, vecs[i].addr, vecs[i].cnt,
                   vecs[i].valid, vecs[i].ir});
        end

        // Async reset mid-execute at cnt_clk=2
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        check("pre_rst_exec", observed(), {1'b0, 8'h01, 8'h01, 2'd2, 1'b1, 16'h4123});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_exec", observed(), 36'h0);
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        check("restart_exec", observed(), {1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 16'h0000});

        // Move to pc=1 then reset during FETCH_WAIT
        step(1'b1, 1'b1, 16'h4123, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        check("wait_pc1", observed(), {1'b1, 8'h01, 8'h01, 2'd0, 1'b0, 16'h4123});
        @(negedge clk);
        imem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_wait", observed(), 36'h0);
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        check("restart_wait", observed(), {1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 16'h0000});
        step(1'b1, 1'b1, 16'h8E7A, 1'b1);
        check("refetch", observed(), {1'b0, 8'h00, 8'h00, 2'd1, 1'b1, 16'h8E7A});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
